// File: rtl/memory_scan_loader.sv
// Serial scan-chain loader: accepts image bytes over valid/ready and shifts them MSB first into the memory bank chain.
// Optional macro SCAN_READBACK_EN returns the previous chain contents as bytes while loading.
`timescale 1ns/1ps
module memory_scan_loader #(
  parameter int CHAIN_BITS = 256,
  parameter int CNT_WIDTH  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_start,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  output logic       byte_ready,
  output logic       scan_enable,
  output logic       scan_in,
  input  logic       scan_out,
  output logic       cpu_halt,
  output logic       busy,
  output logic       done,
  output logic       rb_valid,
  output logic [7:0] rb_byte
);

  localparam int BYTE_COUNT = CHAIN_BITS / 8;
  localparam logic [CNT_WIDTH-1:0] LAST_BYTE = CNT_WIDTH'(BYTE_COUNT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BYTE, SHIFT, FINISH} state_t;

  state_t               state, state_next;
  logic [7:0]           shifter;
  logic [2:0]           bit_cnt;
  logic [CNT_WIDTH-1:0] byte_cnt;
  logic                 byte_ready_d, scan_enable_d, halt_d, done_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (load_start) state_next = WAIT_BYTE;
      WAIT_BYTE: if (byte_valid) state_next = SHIFT;
      SHIFT:     if (bit_cnt == 3'd7)
                   state_next = (byte_cnt == LAST_BYTE) ? FINISH : WAIT_BYTE;
      FINISH:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // NOTE: outputs decode the next state and are then registered, so they change exactly with the state.
  always_comb begin
    byte_ready_d  = (state_next == WAIT_BYTE);
    scan_enable_d = (state_next == SHIFT);
    halt_d        = (state_next != IDLE);
    done_d        = (state_next == FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_ready  <= 1'b0;
      scan_enable <= 1'b0;
      cpu_halt    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      byte_ready  <= byte_ready_d;
      scan_enable <= scan_enable_d;
      cpu_halt    <= halt_d;
      busy        <= halt_d;
      done        <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shifter  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (load_start) byte_cnt <= '0;
        WAIT_BYTE: if (byte_valid) begin
          shifter <= byte_in;
          bit_cnt <= '0;
        end
        SHIFT: begin
          shifter <= {shifter[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Zeros shift in behind each byte, so scan_in idles low between bytes.
  assign scan_in = shifter[7];

`ifdef SCAN_READBACK_EN
  logic [7:0] rb_shift;

  // The tail bit is sampled before the bank moves it, giving the old image MSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_shift <= '0;
      rb_byte  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (state == SHIFT) begin
        rb_shift <= {rb_shift[6:0], scan_out};
        if (bit_cnt == 3'd7) begin
          rb_byte  <= {rb_shift[6:0], scan_out};
          rb_valid <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_scan_out;
  assign unused_scan_out = scan_out;
  assign rb_valid = 1'b0;
  assign rb_byte  = 8'h00;
`endif

endmodule

// File: tb/tb_memory_scan_loader.sv
// Self-checking bench for memory_scan_loader: table-driven byte vectors plus reset, full-load and readback sequences.
// The memory bank chain is modelled as a 256-bit shift register fed by scan_in.
`timescale 1ns/1ps
module tb_memory_scan_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_start = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_ready, scan_enable, scan_in, scan_out;
  logic       cpu_halt, busy, done, rb_valid;
  logic [7:0] rb_byte;

  int checks = 0;
  int errors = 0;

  memory_scan_loader dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .byte_valid  (byte_valid),
    .byte_in     (byte_in),
    .byte_ready  (byte_ready),
    .scan_enable (scan_enable),
    .scan_in     (scan_in),
    .scan_out    (scan_out),
    .cpu_halt    (cpu_halt),
    .busy        (busy),
    .done        (done),
    .rb_valid    (rb_valid),
    .rb_byte     (rb_byte)
  );

  always #5 clk = ~clk;

  // Bank chain model: head at bit 0, tail at bit 255.
  logic [255:0] chain = '0;
  logic         preload = 1'b0;
  always @(posedge clk) begin
    if (preload)          chain <= {32{8'hC3}};
    else if (scan_enable) chain <= {chain[254:0], scan_in};
  end
  assign scan_out = chain[255];

  int se_cnt = 0, done_cnt = 0, rb_cnt = 0, rb_bad = 0;
  always @(negedge clk) begin
    if (scan_enable) se_cnt++;
    if (done)        done_cnt++;
    if (rb_valid) begin
      rb_cnt++;
      if (rb_byte !== 8'hC3) rb_bad++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offers one byte, then samples scan_in for nbits shift cycles.
  task automatic send_byte(input logic [7:0] b, input bit hold, input bit ls, input int nbits,
                           output logic [7:0] got, output int proto_err);
    proto_err  = 0;
    got        = 8'h00;
    byte_in    = b;
    byte_valid = 1'b1;
    load_start = ls;
    tick;
    if (hold) byte_in = 8'hEE;
    else      byte_valid = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      got = {got[6:0], scan_in};
      if (!scan_enable || byte_ready) proto_err++;
      tick;
    end
    byte_valid = 1'b0;
    load_start = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         hold;
    logic [7:0] exp_bits;
  } vec_t;

  vec_t         vecs[3];
  logic [7:0]   got;
  int           pe, tot_pe, ser_err, gap_err, wait_err;
  int           se0, d0, r0, b0;
  logic [255:0] exp_chain;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 8'b1010_0101};
    vecs[1] = '{8'h3C, 1'b0, 8'b0011_1100};
    vecs[2] = '{8'h81, 1'b1, 8'b1000_0001};

    // Reset state
    tick; tick;
    check("rst_scan_enable", scan_enable, 1'b0);
    check("rst_byte_ready",  byte_ready,  1'b0);
    check("rst_cpu_halt",    cpu_halt,    1'b0);
    check("rst_busy",        busy,        1'b0);
    check("rst_done",        done,        1'b0);
    check("rst_rb_valid",    rb_valid,    1'b0);
    check("rst_scan_in",     scan_in,     1'b0);
    rst = 1'b0;
    tick;

    byte_valid = 1'b1;
    tick;
    check("idle_no_ready", byte_ready, 1'b0);
    check("idle_not_busy", busy,       1'b0);
    byte_valid = 1'b0;

    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    check("start_cpu_halt",    cpu_halt,    1'b1);
    check("start_busy",        busy,        1'b1);
    check("start_byte_ready",  byte_ready,  1'b1);
    check("start_scan_enable", scan_enable, 1'b0);

    for (int v = 0; v < 3; v++) begin
      send_byte(vecs[v].data, vecs[v].hold, 1'b0, 8, got, pe);
      check($sformatf("vec%0d_serial", v), got, vecs[v].exp_bits);
      check($sformatf("vec%0d_shift_protocol", v), pe, 0);
      check($sformatf("vec%0d_ready_after", v), byte_ready, 1'b1);
      check($sformatf("vec%0d_gap_se_low", v), scan_enable, 1'b0);
    end

    // Reset after 3 bytes plus 4 bits of the 4th
    send_byte(8'hF0, 1'b0, 1'b0, 4, got, pe);
    check("partial_bits", got, 8'h0F);
    check("partial_still_shifting", scan_enable, 1'b1);
    rst = 1'b1;
    tick;
    check("midrst_scan_enable", scan_enable, 1'b0);
    check("midrst_busy",        busy,        1'b0);
    check("midrst_cpu_halt",    cpu_halt,    1'b0);
    rst = 1'b0;
    tick;

    // Full load of 0x00..0x1F over a chain preloaded with 0xC3
    preload = 1'b1;
    tick;
    preload = 1'b0;
    se0 = se_cnt; d0 = done_cnt; r0 = rb_cnt; b0 = rb_bad;
    tot_pe = 0; ser_err = 0; gap_err = 0; wait_err = 0;
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 5) begin
        for (int k = 0; k < 3; k++) begin
          tick;
          if (!byte_ready || scan_enable) wait_err++;
        end
      end
      send_byte(8'(i), i[0], (i == 10 || i == 11), 8, got, pe);
      tot_pe += pe;
      if (got !== 8'(i)) ser_err++;
      if (i < 31 && (!byte_ready || scan_enable || !cpu_halt)) gap_err++;
    end
    for (int k = 0; k < 4 && !done; k++) tick;
    check("finish_done",        done,        1'b1);
    check("finish_cpu_halt",    cpu_halt,    1'b1);
    check("finish_scan_enable", scan_enable, 1'b0);
    check("finish_byte_ready",  byte_ready,  1'b0);
    tick;
    check("after_done_pulse",    done,     1'b0);
    check("after_done_cpu_halt", cpu_halt, 1'b0);
    check("after_done_busy",     busy,     1'b0);
    tick; tick;

    for (int i = 0; i < 32; i++) exp_chain[255 - 8*i -: 8] = 8'(i);
    check("load_se_cycles",   se_cnt - se0,   256);
    check("load_done_pulses", done_cnt - d0,  1);
    check("load_serial_bits", ser_err,        0);
    check("load_shift_proto", tot_pe,         0);
    check("load_gap_proto",   gap_err,        0);
    check("load_idle_wait",   wait_err,       0);
    check("chain_addr0",      chain[7:0],     8'h1F);
    check("chain_led_word",   chain[255:248], 8'h00);
    check("chain_image",      chain == exp_chain, 1'b1);
`ifdef SCAN_READBACK_EN
    check("rb_pulses",    rb_cnt - r0, 32);
    check("rb_bad_bytes", rb_bad - b0, 0);
`else
    check("rb_never_valid", rb_cnt, 0);
    check("rb_byte_zero",   rb_byte, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_scan_loader.md
Name: memory_scan_loader

Overview:
- Sequences the memory bank's serial scan chain so a host can load a full program image byte-by-byte over a valid/ready handshake.
- Holds the CPU halted while the chain is shifting.
- Sits between the top-level programming pins and the memory bank's scan_enable/scan_in/scan_out.
- Optionally returns the previous chain contents as bytes while loading.

Parameters:
- CHAIN_BITS, 256, total scan chain length in bits (31 x 8 memory + 1 button + 7 LED). Must be a multiple of 8.
- BYTE_COUNT, CHAIN_BITS/8, number of bytes per full load (derived; do not override).
- CNT_WIDTH, 6, width of the byte counter. Must satisfy 2^CNT_WIDTH > BYTE_COUNT.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- load_start  input  1  single-cycle request to begin a full-chain load; ignored unless IDLE
- byte_valid  input  1  host has a byte on byte_in
- byte_in  input  8  next image byte
- byte_ready  output  1  loader accepts byte_in this cycle
- scan_enable  output  1  to memory bank scan_enable
- scan_in  output  1  to memory bank scan_in (head of chain)
- scan_out  input  1  from memory bank scan_out (tail of chain)
- cpu_halt  output  1  CPU must not execute or write memory while high
- busy  output  1  load in progress
- done  output  1  one-cycle pulse when the last bit has been shifted
- rb_valid  output  1  readback byte valid pulse (SCAN_READBACK_EN only)
- rb_byte  output  8  readback byte (SCAN_READBACK_EN only)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE; scan_enable, scan_in, byte_ready, cpu_halt, busy, done, rb_valid = 0; rb_byte = 0; counters = 0.
- Reset mid-load: the next edge forces IDLE and drops scan_enable. A partially shifted chain is left as-is, with no recovery.
- FSM states: IDLE, WAIT_BYTE, SHIFT, FINISH.
- IDLE:
  - load_start=1 -> WAIT_BYTE; byte_cnt=0; cpu_halt=1 and busy=1 from the next cycle.
- WAIT_BYTE:
  - byte_ready=1 and scan_enable=0.
  - byte_valid&byte_ready -> capture byte_in into an 8-bit shifter, bit_cnt=0 -> SHIFT.
  - byte_valid low -> wait indefinitely with no timeout.
- SHIFT:
  - Exactly 8 consecutive cycles with scan_enable=1 and byte_ready=0.
  - scan_in = shifter[7] (MSB first); the shifter shifts left each cycle.
  - After the 8th bit, byte_cnt increments. If byte_cnt == BYTE_COUNT-1 before the increment -> FINISH, else -> WAIT_BYTE.
  - The minimum gap between bytes is 1 cycle, with scan_enable low in the gap.
- FINISH:
  - One cycle: scan_enable=0, done=1.
  - Next cycle -> IDLE; cpu_halt=0 and busy=0.
- Chain ordering: the first bit shifted ends at the chain tail. The first byte supplied therefore becomes the LED/button word, and the last byte supplied lands in memory address 0.
- Exactly CHAIN_BITS scan_enable-high cycles per load.
- load_start while busy: ignored, with no restart.
- byte_valid in IDLE, SHIFT or FINISH: not accepted; byte_ready is 0.
- cpu_halt is asserted no later than the first scan_enable cycle and released no earlier than the cycle after done.

Optional Feature:
- Macro: SCAN_READBACK_EN.
- Defined:
  - In each SHIFT cycle, scan_out is sampled into an 8-bit readback shifter, MSB first, before the bank shifts.
  - After the 8th sample, rb_byte is updated and rb_valid pulses for 1 cycle (same cycle the FSM leaves SHIFT).
  - The BYTE_COUNT readback bytes reproduce the previous chain image in the same order that bytes are supplied.
- Undefined:
  - rb_valid and rb_byte are tied to 0.
  - scan_out is unused, and no readback registers are built.

Test Plan:
- Reset, then pulse load_start -> cpu_halt=1, busy=1, byte_ready=1 on cycle+1; scan_enable=0.
- Byte 0xA5 with byte_valid held -> scan_in sequence 1,0,1,0,0,1,0,1 over 8 scan_enable cycles, then byte_ready=1 again.
- Full load of 32 bytes 0x00..0x1F, with the chain modelled by a 256-bit shift register -> 256 scan_enable cycles, done pulses once, cpu_halt drops the cycle after done; memory addr 0 holds 0x1F, LED word 0x00.
- Assert rst after 3 bytes plus 4 bits of the 4th -> scan_enable=0, busy=0 and cpu_halt=0 on the next cycle; a new load_start then loads correctly.
- load_start pulsed mid-load and byte_valid held high during SHIFT -> no restart, no extra byte accepted, and byte_cnt unchanged except by completed bytes.
- SCAN_READBACK_EN with the chain preloaded with image 0xC3 repeated -> 32 rb_valid pulses, each with rb_byte=0xC3, while a new image loads.
